// File: rtl/seg7_decoder_if.sv
// Output stream of the seven-segment decoder: decoded frame, its valid/ready
// handshake and the overrun pulse.
interface seg7_decoder_if;
    logic        dout_valid;
    logic        dout_ready;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        overrun;

    modport master (
        output dout_valid,
        output digits,
        output digit_err,
        output overrun,
        input  dout_ready
    );

    modport slave (
        input  dout_valid,
        input  digits,
        input  digit_err,
        input  overrun,
        output dout_ready
    );
endinterface

// File: rtl/seg7_decoder.sv
// Debounces four active-low 7-segment fields and decodes them to BCD frames.
// Optional macro SEG7_DEC_BLANK_EN: an all-dark field decodes to 4'hF without error.
module seg7_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [27:0]     led_pins,
    seg7_decoder_if.master  out
);

    localparam logic [7:0] CNT_SAT   = 8'(STABLE_CYCLES);
    // The edge that samples the pattern for the Nth time sees a count of N-2.
    localparam logic [7:0] COMMIT_AT = 8'(STABLE_CYCLES - 2);

    logic [27:0] sample_q;
    logic [27:0] committed_q;
    logic        committed_vld;
    logic [7:0]  stable_cnt;

    logic        valid_q;
    logic [15:0] digits_q;
    logic [3:0]  err_q;
    logic        overrun_q;

    logic        same;
    logic        commit;
    logic        accept;
    logic [15:0] dec_digits;
    logic [3:0]  dec_err;

    assign same   = (led_pins == sample_q);
    assign commit = same && (stable_cnt >= COMMIT_AT) &&
                    (!committed_vld || (led_pins != committed_q));
    assign accept = valid_q && out.dout_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_field
            logic [6:0] lit;
            logic [3:0] code;
            logic       bad;

            assign lit = ~led_pins[7*gi +: 7];

            always_comb begin
                code = 4'hE;
                bad  = 1'b0;
                case (lit)
                    7'b1111110: code = 4'd0;
                    7'b0110000: code = 4'd1;
                    7'b1101101: code = 4'd2;
                    7'b1111001: code = 4'd3;
                    7'b0110011: code = 4'd4;
                    7'b1011011: code = 4'd5;
                    7'b1011111: code = 4'd6;
                    7'b1110000: code = 4'd7;
                    7'b1111111: code = 4'd8;
                    7'b1111011: code = 4'd9;
`ifdef SEG7_DEC_BLANK_EN
                    7'b0000000: code = 4'hF;
`else
                    7'b0000000: begin
                        code = 4'hE;
                        bad  = 1'b1;
                    end
`endif
                    default: begin
                        code = 4'hE;
                        bad  = 1'b1;
                    end
                endcase
            end

            assign dec_digits[4*gi +: 4] = code;
            assign dec_err[gi]           = bad;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q      <= '0;
            stable_cnt    <= '0;
            committed_q   <= '0;
            committed_vld <= 1'b0;
            valid_q       <= 1'b0;
            digits_q      <= '0;
            err_q         <= '0;
            overrun_q     <= 1'b0;
        end else begin
            sample_q <= led_pins;

            if (!same) begin
                stable_cnt <= '0;
            end else if (stable_cnt < CNT_SAT) begin
                stable_cnt <= stable_cnt + 8'd1;
            end

            // Overrun only when a pending frame is lost, not when it is consumed.
            overrun_q <= commit && valid_q && !out.dout_ready;

            if (commit) begin
                committed_q   <= led_pins;
                committed_vld <= 1'b1;
                digits_q      <= dec_digits;
                err_q         <= dec_err;
                valid_q       <= 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out.dout_valid = valid_q;
    assign out.digits     = digits_q;
    assign out.digit_err  = err_q;
    assign out.overrun    = overrun_q;

endmodule
